// File: rtl/mips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the MIPS pipeline control blocks:
//   - ctrl_state_e : stall-controller FSM encoding (RUN / MEM_WAIT)
//   - default parameter constants for the stall controller
//   - IdExNopCtrl  : all-zero control word loaded into ID/EX for a bubble
//   - is_mem_access: helper flagging a MEM-stage load or store
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_e;

    localparam int unsigned MaxHazStallDefault = 2;
    localparam int unsigned MemTimeoutDefault  = 16;
    localparam int unsigned CntWDefault        = 16;

    // ID/EX control word: {wb_en, mem_r_en, mem_w_en, exe_cmd[3:0], b, s}.
    localparam int unsigned            IdExCtrlW   = 9;
    localparam logic [IdExCtrlW-1:0]   IdExNopCtrl = '0;

    function automatic logic is_mem_access(logic mem_r_en, logic mem_w_en);
        return mem_r_en | mem_w_en;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter with synchronous clear and enable that stops at Limit.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (count -> 0)
//   clr_i   synchronous clear, wins over en_i
//   en_i    count enable
//   cnt_o   current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned      Width = 4,
    parameter logic [Width-1:0] Limit = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// ----------------------------------------------------------------------------
// pipeline_stall_controller
// Turns the RAW hazard flag, branch resolution and SRAM readiness into the
// freeze / bubble / flush controls of the 5-stage MIPS pipeline, sequences
// multi-cycle SRAM waits and supervises stall length.
// Ports:
//   clk, rst (async, active low)
//   Hazard_Detected, Branch_Taken, Mem_R_EN, Mem_W_EN, SRAM_Ready  : status in
//   Freeze_PC, Freeze_IF_ID, Bubble_ID_EX, Flush_IF_ID, Freeze_Back : controls
//   Stall_Error  sticky, hazard stall ran longer than MAX_HAZ_STALL
//   Mem_Timeout  sticky, SRAM wait reached MEM_TIMEOUT cycles in MEM_WAIT
// Optional (macro STALL_PERF_CNT_EN):
//   Haz_Stall_Cnt, Mem_Stall_Cnt, Flush_Cnt  saturating performance counters
// ----------------------------------------------------------------------------
module pipeline_stall_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MAX_HAZ_STALL = MaxHazStallDefault,
    parameter int unsigned MEM_TIMEOUT   = MemTimeoutDefault,  // must be >= 1
    parameter int unsigned CNT_W         = CntWDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Hazard_Detected,
    input  logic             Branch_Taken,
    input  logic             Mem_R_EN,
    input  logic             Mem_W_EN,
    input  logic             SRAM_Ready,
    output logic             Freeze_PC,
    output logic             Freeze_IF_ID,
    output logic             Bubble_ID_EX,
    output logic             Flush_IF_ID,
    output logic             Freeze_Back,
`ifdef STALL_PERF_CNT_EN
    output logic [CNT_W-1:0] Haz_Stall_Cnt,
    output logic [CNT_W-1:0] Mem_Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
`endif
    output logic             Stall_Error,
    output logic             Mem_Timeout
);

    localparam int unsigned HazCntW = $clog2(MAX_HAZ_STALL + 2);
    localparam int unsigned MemCntW = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e        state_d, state_q;
    logic               stall_err_d, stall_err_q;
    logic               mem_to_d, mem_to_q;
    logic               freeze, branch_flush, haz_stall;
    logic               haz_clr, mem_clr, mem_en;
    logic [HazCntW-1:0] haz_cnt;
    logic [MemCntW-1:0] mem_cnt;

    // A pending SRAM access freezes everything; branch/hazard are only
    // looked at once the pipe is moving again.
    assign freeze       = is_mem_access(Mem_R_EN, Mem_W_EN) & ~SRAM_Ready;
    assign branch_flush = ~freeze & Branch_Taken;
    assign haz_stall    = ~freeze & ~Branch_Taken & Hazard_Detected;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (freeze)     state_d = MEM_WAIT;
            MEM_WAIT: if (SRAM_Ready) state_d = RUN;
            default:                  state_d = RUN;
        endcase
    end

    // Hazard run length: frozen cycles hold, any unstalled cycle clears.
    assign haz_clr = ~freeze & ~haz_stall;

    sat_counter #(
        .Width (HazCntW),
        .Limit (HazCntW'(MAX_HAZ_STALL + 1))
    ) u_haz_wdog (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (haz_clr),
        .en_i   (haz_stall),
        .cnt_o  (haz_cnt)
    );

    // Wait length: counts MEM_WAIT cycles, cleared whenever we are (or are
    // about to be) back in RUN so the release cycle never trips the timeout.
    assign mem_clr = (state_d == RUN);
    assign mem_en  = (state_q == MEM_WAIT);

    sat_counter #(
        .Width (MemCntW),
        .Limit (MemCntW'(MEM_TIMEOUT))
    ) u_mem_wdog (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (mem_clr),
        .en_i   (mem_en),
        .cnt_o  (mem_cnt)
    );

    always_comb begin
        stall_err_d = stall_err_q;
        mem_to_d    = mem_to_q;
        // This stall would be number MAX_HAZ_STALL+1 in a row.
        if (haz_stall && (haz_cnt >= HazCntW'(MAX_HAZ_STALL))) begin
            stall_err_d = 1'b1;
        end
        // Count is about to reach MEM_TIMEOUT.
        if (mem_en && !mem_clr && (mem_cnt >= MemCntW'(MEM_TIMEOUT - 1))) begin
            mem_to_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_err_q <= 1'b0;
            mem_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_err_q <= stall_err_d;
            mem_to_q    <= mem_to_d;
        end
    end

    // Controls are combinational; gating with rst forces them low while reset
    // is asserted regardless of the status inputs.
    assign Freeze_Back  = rst & freeze;
    assign Freeze_PC    = rst & (freeze | haz_stall);
    assign Freeze_IF_ID = rst & (freeze | haz_stall);
    assign Bubble_ID_EX = rst & (branch_flush | haz_stall);
    assign Flush_IF_ID  = rst & branch_flush;
    assign Stall_Error  = stall_err_q;
    assign Mem_Timeout  = mem_to_q;

`ifdef STALL_PERF_CNT_EN
    sat_counter #(
        .Width (CNT_W),
        .Limit ('1)
    ) u_perf_haz (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (1'b0),
        .en_i   (haz_stall),
        .cnt_o  (Haz_Stall_Cnt)
    );

    sat_counter #(
        .Width (CNT_W),
        .Limit ('1)
    ) u_perf_mem (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (1'b0),
        .en_i   (freeze),
        .cnt_o  (Mem_Stall_Cnt)
    );

    sat_counter #(
        .Width (CNT_W),
        .Limit ('1)
    ) u_perf_flush (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (1'b0),
        .en_i   (branch_flush),
        .cnt_o  (Flush_Cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ----------------------------------------------------------------------------
// tb_pipeline_stall_controller
// Scoreboard bench: each driven cycle pushes the expected outputs/state from a
// small behavioural model; a monitor pops and compares just before the edge.
// ----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam int MaxHaz = 2;
    localparam int MemTo  = 16;
    localparam int CntW   = 16;

    logic clk, rst;
    logic Hazard_Detected, Branch_Taken, Mem_R_EN, Mem_W_EN, SRAM_Ready;
    logic Freeze_PC, Freeze_IF_ID, Bubble_ID_EX, Flush_IF_ID, Freeze_Back;
    logic Stall_Error, Mem_Timeout;
`ifdef STALL_PERF_CNT_EN
    logic [CntW-1:0] Haz_Stall_Cnt, Mem_Stall_Cnt, Flush_Cnt;
`endif

    pipeline_stall_controller #(
        .MAX_HAZ_STALL (MaxHaz),
        .MEM_TIMEOUT   (MemTo),
        .CNT_W         (CntW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Hazard_Detected (Hazard_Detected),
        .Branch_Taken    (Branch_Taken),
        .Mem_R_EN        (Mem_R_EN),
        .Mem_W_EN        (Mem_W_EN),
        .SRAM_Ready      (SRAM_Ready),
        .Freeze_PC       (Freeze_PC),
        .Freeze_IF_ID    (Freeze_IF_ID),
        .Bubble_ID_EX    (Bubble_ID_EX),
        .Flush_IF_ID     (Flush_IF_ID),
        .Freeze_Back     (Freeze_Back),
`ifdef STALL_PERF_CNT_EN
        .Haz_Stall_Cnt   (Haz_Stall_Cnt),
        .Mem_Stall_Cnt   (Mem_Stall_Cnt),
        .Flush_Cnt       (Flush_Cnt),
`endif
        .Stall_Error     (Stall_Error),
        .Mem_Timeout     (Mem_Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Freeze_Back, Freeze_PC, Freeze_IF_ID, Bubble_ID_EX, Flush_IF_ID, Stall_Error, Mem_Timeout}
    logic [6:0] dut_outs;
    assign dut_outs = {Freeze_Back, Freeze_PC, Freeze_IF_ID, Bubble_ID_EX, Flush_IF_ID,
                       Stall_Error, Mem_Timeout};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string      tag;
        logic [6:0] outs;
        logic       st;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural reference state.
    int   m_haz, m_wait, m_perf_haz, m_perf_mem, m_perf_flush;
    logic m_state, m_serr, m_mto;

    task automatic model_reset();
        m_haz = 0; m_wait = 0; m_state = 1'b0; m_serr = 1'b0; m_mto = 1'b0;
        m_perf_haz = 0; m_perf_mem = 0; m_perf_flush = 0;
    endtask

    task automatic model_step();
        logic fz, hs, bf, n;
        fz = (Mem_R_EN | Mem_W_EN) & ~SRAM_Ready;
        bf = ~fz & Branch_Taken;
        hs = ~fz & ~Branch_Taken & Hazard_Detected;
        n  = (m_state == 1'b0) ? fz : ~SRAM_Ready;
        if (!fz) begin
            if (hs) begin
                if (m_haz >= MaxHaz) m_serr = 1'b1;
                if (m_haz < MaxHaz + 1) m_haz++;
            end else begin
                m_haz = 0;
            end
        end
        if (n == 1'b0) begin
            m_wait = 0;
        end else if (m_state == 1'b1) begin
            if (m_wait >= MemTo - 1) m_mto = 1'b1;
            if (m_wait < MemTo) m_wait++;
        end
        m_perf_haz   += int'(hs);
        m_perf_mem   += int'(fz);
        m_perf_flush += int'(bf);
        m_state = n;
    endtask

    task automatic drive(input string tag, input logic haz, input logic br, input logic mr,
                         input logic mw, input logic rdy);
        exp_t e;
        logic fz, hs, bf;
        @(negedge clk);
        Hazard_Detected = haz; Branch_Taken = br;
        Mem_R_EN = mr; Mem_W_EN = mw; SRAM_Ready = rdy;
        fz = (mr | mw) & ~rdy;
        bf = ~fz & br;
        hs = ~fz & ~br & haz;
        e.tag  = tag;
        e.outs = {fz, fz | hs, fz | hs, bf | hs, bf, m_serr, m_mto};
        e.st   = m_state;
        exp_q.push_back(e);
        @(posedge clk);
        #1 model_step();
    endtask

    // Monitor: compare just before the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_outs"}, 32'(dut_outs), 32'(e.outs));
            check_eq({e.tag, "_state"}, 32'(dut.state_q), 32'(e.st));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0;
        Hazard_Detected = 1'b0; Branch_Taken = 1'b0;
        Mem_R_EN = 1'b0; Mem_W_EN = 1'b0; SRAM_Ready = 1'b0;
        model_reset();
        #2;
        check_eq("reset_outs", 32'(dut_outs), 32'd0);
        // Status active during reset must not leak through.
        Hazard_Detected = 1'b1; Mem_W_EN = 1'b1;
        #1;
        check_eq("reset_gated_outs", 32'(dut_outs), 32'd0);
        check_eq("reset_state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        Hazard_Detected = 1'b0; Mem_W_EN = 1'b0;
        rst = 1'b1;

        drive("idle", 0, 0, 0, 0, 0);
        // Two hazard cycles: legal.
        repeat (2) drive("haz2", 1, 0, 0, 0, 0);
        drive("haz2_end", 0, 0, 0, 0, 0);
        // Ready in the same cycle as the access: no freeze.
        drive("mem_fast", 0, 0, 1, 0, 1);
        drive("mem_fast_w", 1, 0, 0, 1, 1);
        drive("idle", 0, 0, 0, 0, 0);
        // Branch beats hazard.
        drive("br_haz", 1, 1, 0, 0, 0);
        // Three hazard cycles: Stall_Error after the third.
        repeat (3) drive("haz3", 1, 0, 0, 0, 0);
        drive("haz3_end", 0, 0, 0, 0, 0);
        drive("sticky", 0, 0, 0, 0, 0);
        // Five-cycle load wait with a branch during it; flush only on release.
        drive("ld_w1", 0, 0, 1, 0, 0);
        drive("ld_w2", 0, 0, 1, 0, 0);
        drive("ld_w3_br", 1, 1, 1, 0, 0);
        drive("ld_w4", 0, 0, 1, 0, 0);
        drive("ld_w5_br", 0, 1, 1, 0, 0);
        drive("ld_rel_br", 0, 1, 1, 0, 1);
        drive("idle", 0, 0, 0, 0, 0);
        // Long store wait: Mem_Timeout, freeze held.
        repeat (20) drive("st_long", 0, 0, 0, 1, 0);
        drive("st_rel", 0, 0, 0, 1, 1);
        drive("idle", 0, 0, 0, 0, 0);
        // Reset during MEM_WAIT: outputs drop immediately.
        repeat (3) drive("ld_pre_rst", 0, 0, 1, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_mid_wait_outs", 32'(dut_outs), 32'd0);
        check_eq("rst_mid_wait_state", 32'(dut.state_q), 32'd0);
        model_reset();
        @(negedge clk);
        Mem_R_EN = 1'b0;
        rst = 1'b1;
        // 3 hazard, 4 memory freeze, 1 flush cycles.
        repeat (3) drive("perf_haz", 1, 0, 0, 0, 0);
        repeat (4) drive("perf_mem", 0, 0, 1, 0, 0);
        drive("perf_rel", 0, 0, 1, 0, 1);
        drive("perf_br", 0, 1, 0, 0, 0);
        drive("idle", 0, 0, 0, 0, 0);
        @(negedge clk);
        #5;
`ifdef STALL_PERF_CNT_EN
        check_eq("perf_haz_cnt", 32'(Haz_Stall_Cnt), 32'd3);
        check_eq("perf_mem_cnt", 32'(Mem_Stall_Cnt), 32'd4);
        check_eq("perf_flush_cnt", 32'(Flush_Cnt), 32'd1);
        check_eq("perf_model_haz", 32'(m_perf_haz), 32'd3);
`endif
        check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumer side of the RAW hazard flag: takes the hazard-detect output plus branch and memory-ready status, and drives freeze, bubble and flush controls for the 5-stage MIPS pipeline (IF/ID/EXE/MEM/WB).
- Sequences multi-cycle SRAM waits through a small FSM.
- Supervises stall length with a watchdog.
- Sits beside the hazard unit in the top-level datapath; outputs go to the PC register, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- MAX_HAZ_STALL, 2, maximum legal consecutive hazard-stall cycles before Stall_Error is set.
- MEM_TIMEOUT, 16, maximum SRAM wait cycles before Mem_Timeout is set.
- CNT_W, 16, width of performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- Hazard_Detected  in  1  RAW hazard flag for the instruction in ID.
- Branch_Taken  in  1  branch resolved taken in EXE.
- Mem_R_EN  in  1  MEM-stage load.
- Mem_W_EN  in  1  MEM-stage store.
- SRAM_Ready  in  1  SRAM completes access this cycle.
- Freeze_PC  out  1  hold PC.
- Freeze_IF_ID  out  1  hold IF/ID register.
- Bubble_ID_EX  out  1  load NOP (all control bits 0) into ID/EX.
- Flush_IF_ID  out  1  clear IF/ID to NOP.
- Freeze_Back  out  1  hold ID/EX, EX/MEM and MEM/WB (SRAM wait).
- Stall_Error  out  1  sticky: hazard stall exceeded MAX_HAZ_STALL.
- Mem_Timeout  out  1  sticky: SRAM wait exceeded MEM_TIMEOUT.

Behaviour:
- Clock and reset: single clock domain, rising edge; rst low asynchronously forces state RUN, clears all counters and sticky flags, and drives all outputs 0.
- FSM states: RUN, MEM_WAIT.
- RUN → MEM_WAIT when (Mem_R_EN|Mem_W_EN) && !SRAM_Ready.
- MEM_WAIT → RUN on the cycle SRAM_Ready=1.
- Freeze_Back:
  - Combinational, zero latency.
  - Equals 1 when (Mem_R_EN|Mem_W_EN) && !SRAM_Ready, in either state.
  - While Freeze_Back=1, Freeze_PC=Freeze_IF_ID=1 as well (whole pipe frozen), and Bubble_ID_EX=0, Flush_IF_ID=0.
  - Branch and hazard inputs are ignored while frozen; they are re-evaluated on the release cycle.
- Priority when not frozen: Branch_Taken > Hazard_Detected.
- Branch_Taken=1:
  - Flush_IF_ID=1 and Bubble_ID_EX=1 for that cycle.
  - Freeze_PC=0 (PC loads the branch target).
  - Any simultaneous hazard is discarded because the ID instruction is squashed.
- Hazard_Detected=1 with no branch:
  - Freeze_PC=1, Freeze_IF_ID=1, Bubble_ID_EX=1.
  - Flush_IF_ID=0.
- Otherwise all control outputs are 0.
- Hazard stall counter:
  - Increments on each cycle a hazard stall is issued.
  - Clears on any cycle without one; frozen cycles hold it.
  - When it would reach MAX_HAZ_STALL+1, set Stall_Error (sticky until reset).
  - The stall itself is still issued.
- SRAM wait counter:
  - Counts cycles spent in MEM_WAIT; clears on entry to RUN.
  - When it reaches MEM_TIMEOUT, set Mem_Timeout (sticky).
  - Freeze continues; the block never forces release.
- Both counters saturate and do not wrap.
- Reset mid-wait: returns to RUN immediately; outputs go to 0 asynchronously.
- SRAM_Ready=1 on the same cycle the access arrives: no freeze and no state change.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined: adds outputs Haz_Stall_Cnt [CNT_W-1:0], Mem_Stall_Cnt [CNT_W-1:0], Flush_Cnt [CNT_W-1:0].
  - Each counts cycles of hazard stall, memory freeze and branch flush respectively.
  - Each saturates at all-ones and resets to 0.
- Undefined: the ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - State encoding: RUN=1'b0, MEM_WAIT=1'b1.
  - Default parameter constants.
  - The NOP control-bit constant used for bubbles.
- One natural sub-module, sat_counter (width- and limit-parameterised, clear, enable, saturate), instantiated for the watchdog counters and the perf counters.

Test Plan:
- Hazard_Detected=1 for 2 cycles, no memory access → Freeze_PC=Freeze_IF_ID=Bubble_ID_EX=1 both cycles; Stall_Error stays 0; all outputs return to 0 on cycle 3.
- Hazard_Detected held 3 cycles (MAX_HAZ_STALL=2) → Stall_Error rises the cycle after the third stall cycle and stays 1 until rst low.
- Branch_Taken=1 and Hazard_Detected=1 together → Flush_IF_ID=1, Bubble_ID_EX=1, Freeze_PC=0.
- Mem_R_EN=1, SRAM_Ready=0 for 5 cycles then 1 → Freeze_Back, Freeze_PC and Freeze_IF_ID high exactly 5 cycles; FSM is in MEM_WAIT on cycles 2-5 and returns to RUN; a Branch_Taken asserted during the wait produces no flush until release.
- SRAM_Ready held 0 for 20 cycles (MEM_TIMEOUT=16) → Mem_Timeout set at wait cycle 16; freeze is maintained until SRAM_Ready.
- rst low during MEM_WAIT → all outputs 0 immediately, state RUN. With STALL_PERF_CNT_EN, after 3 hazard, 4 memory and 1 flush cycles: Haz_Stall_Cnt=3, Mem_Stall_Cnt=4, Flush_Cnt=1.
